// File: rtl/parking_pkg.sv
`default_nettype none
// parking_pkg: lane FSM states, sensor patterns and popcount helper for parking_lot_counter.
// Revision 1.0
package parking_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_A1       = 3'd1,
        ST_B1       = 3'd2,
        ST_AB_IN    = 3'd3,
        ST_AB_OUT   = 3'd4,
        ST_IN_TAIL  = 3'd5,
        ST_OUT_TAIL = 3'd6
    } lane_state_t;

    // Sensor patterns are {a, b}; 1 = beam blocked.
    localparam logic [1:0] S_CLR = 2'b00;
    localparam logic [1:0] S_A   = 2'b10;
    localparam logic [1:0] S_B   = 2'b01;
    localparam logic [1:0] S_AB  = 2'b11;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/parking_lane_decoder.sv
`default_nettype none
// parking_lane_decoder: one lane's a/b sensor FSM with registered entry/exit pulses.
// Optional stall abort when PARKING_GATE_TIMEOUT_EN is defined. Revision 1.0
module parking_lane_decoder
    import parking_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic a,
    input  logic b,
    output logic entry_pulse,
    output logic exit_pulse,
    output logic timeout_pulse
);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("parking_lane_decoder: TIMEOUT must be at least 1");
    end

    lane_state_t state;
    lane_state_t state_next;
    logic        entry_next;
    logic        exit_next;
    logic        armed;
    logic        timeout_hit;
    logic [1:0]  ab;

    assign ab = {a, b};

    always_comb begin
        state_next = state;
        entry_next = 1'b0;
        exit_next  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (armed) begin
                    if (ab == S_A)      state_next = ST_A1;
                    else if (ab == S_B) state_next = ST_B1;
                end
            end
            ST_A1: begin
                if (ab == S_CLR)     state_next = ST_IDLE;
                else if (ab == S_AB) state_next = ST_AB_IN;
            end
            ST_B1: begin
                if (ab == S_CLR)     state_next = ST_IDLE;
                else if (ab == S_AB) state_next = ST_AB_OUT;
            end
            ST_AB_IN: begin
                if (ab == S_A)      state_next = ST_A1;
                else if (ab == S_B) state_next = ST_IN_TAIL;
            end
            ST_AB_OUT: begin
                if (ab == S_B)      state_next = ST_B1;
                else if (ab == S_A) state_next = ST_OUT_TAIL;
            end
            ST_IN_TAIL: begin
                if (ab == S_AB) begin
                    state_next = ST_AB_IN;
                end else if (ab == S_CLR) begin
                    state_next = ST_IDLE;
                    entry_next = 1'b1;
                end
            end
            ST_OUT_TAIL: begin
                if (ab == S_AB) begin
                    state_next = ST_AB_OUT;
                end else if (ab == S_CLR) begin
                    state_next = ST_IDLE;
                    exit_next  = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            entry_pulse <= 1'b0;
            exit_pulse  <= 1'b0;
        end else begin
            state       <= timeout_hit ? ST_IDLE : state_next;
            entry_pulse <= entry_next;
            exit_pulse  <= exit_next;
        end
    end

`ifdef PARKING_GATE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] stall_cnt;

    // The counter holds cycles already spent in the current state, so the
    // abort lands on the TIMEOUT-th consecutive cycle in a non-IDLE state.
    assign timeout_hit = (state != ST_IDLE) && (state_next == state) &&
                         (stall_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt     <= '0;
            armed         <= 1'b1;
            timeout_pulse <= 1'b0;
        end else begin
            timeout_pulse <= timeout_hit;
            if (timeout_hit || (state_next != state) || (state == ST_IDLE))
                stall_cnt <= '0;
            else
                stall_cnt <= stall_cnt + 1'b1;
            if (timeout_hit)
                armed <= 1'b0;
            else if ((state == ST_IDLE) && (ab == S_CLR))
                armed <= 1'b1;
        end
    end
`else
    assign timeout_hit   = 1'b0;
    assign armed         = 1'b1;
    assign timeout_pulse = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/parking_lot_counter.sv
`default_nettype none
// parking_lot_counter: N_LANES gate decoders feeding a saturating occupancy counter with sticky err.
// Lane stall timeout enabled by PARKING_GATE_TIMEOUT_EN. Revision 1.0
module parking_lot_counter
    import parking_pkg::*;
#(
    parameter int N_LANES  = 2,
    parameter int CAPACITY = 100,
    parameter int CNT_W    = 8,
    parameter int TIMEOUT  = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_LANES-1:0] a,
    input  logic [N_LANES-1:0] b,
    input  logic               clear_err,
    output logic [CNT_W-1:0]   count,
    output logic               full,
    output logic               empty,
    output logic [N_LANES-1:0] entry_pulse,
    output logic [N_LANES-1:0] exit_pulse,
    output logic               err,
    output logic [N_LANES-1:0] timeout_pulse
);

    localparam int SW = CNT_W + 4;
    localparam logic signed [SW-1:0] CAP_S = SW'(CAPACITY);

    if ((N_LANES < 1) || (N_LANES > 8) || (CAPACITY >= (1 << CNT_W))) begin : g_bad_params
        $error("parking_lot_counter: illegal N_LANES/CAPACITY/CNT_W combination");
    end

    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        parking_lane_decoder #(
            .TIMEOUT (TIMEOUT)
        ) u_lane (
            .clk           (clk),
            .reset         (reset),
            .a             (a[i]),
            .b             (b[i]),
            .entry_pulse   (entry_pulse[i]),
            .exit_pulse    (exit_pulse[i]),
            .timeout_pulse (timeout_pulse[i])
        );
    end

    logic [3:0]            n_in;
    logic [3:0]            n_out;
    logic signed [SW-1:0]  sum;
    logic                  over;
    logic                  under;

    assign n_in  = popcount8(8'(entry_pulse));
    assign n_out = popcount8(8'(exit_pulse));

    // Four guard bits keep the signed sum clear of wrap for up to 8 lanes.
    always_comb begin
        sum   = signed'({4'b0000, count})
              + signed'({{(SW-4){1'b0}}, n_in})
              - signed'({{(SW-4){1'b0}}, n_out});
        over  = (sum > CAP_S);
        under = (sum < 0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            err   <= 1'b0;
        end else begin
            if (over)       count <= CNT_W'(CAPACITY);
            else if (under) count <= '0;
            else            count <= sum[CNT_W-1:0];

            if (over || under) err <= 1'b1;
            else if (clear_err) err <= 1'b0;
        end
    end

    assign full  = (count == CNT_W'(CAPACITY));
    assign empty = (count == '0);

endmodule
`default_nettype wire

// File: tb/tb_parking_lot_counter.sv
`default_nettype none
// tb_parking_lot_counter: directed lane sequences with a pulse-driven scoreboard monitor.
module tb_parking_lot_counter;

    localparam int NL  = 2;
    localparam int CAP = 100;
    localparam int CW  = 8;
    localparam int TMO = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [NL-1:0] a, b;
    logic          clear_err;
    logic [CW-1:0] count;
    logic          full, empty, err;
    logic [NL-1:0] entry_pulse, exit_pulse, timeout_pulse;

    always #5 clk = ~clk;

    parking_lot_counter #(
        .N_LANES (NL), .CAPACITY (CAP), .CNT_W (CW), .TIMEOUT (TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .a             (a),
        .b             (b),
        .clear_err     (clear_err),
        .count         (count),
        .full          (full),
        .empty         (empty),
        .entry_pulse   (entry_pulse),
        .exit_pulse    (exit_pulse),
        .err           (err),
        .timeout_pulse (timeout_pulse)
    );

    typedef struct {
        logic [1:0] ent;
        logic [1:0] ext;
        logic [1:0] tmo;
        int         prev;
        int         cnt;
        logic       err;
    } exp_t;

    exp_t q[$];
    exp_t mr;
    int   checks = 0;
    int   errors = 0;
    bit   mon_busy = 1'b0;
    int   model_count = 0;
    bit   model_err = 1'b0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: every cycle with a pulse consumes one expected record.
    always begin
        @(negedge clk);
        if ((|entry_pulse) || (|exit_pulse) || (|timeout_pulse)) begin
            if (q.size() == 0) begin
                check("unexpected_pulse", int'({entry_pulse, exit_pulse, timeout_pulse}), 0);
            end else begin
                mon_busy = 1'b1;
                mr = q.pop_front();
                check("entry_pulse", int'(entry_pulse), int'(mr.ent));
                check("exit_pulse", int'(exit_pulse), int'(mr.ext));
                check("timeout_pulse", int'(timeout_pulse), int'(mr.tmo));
                check("count_during_pulse", int'(count), mr.prev);
                @(negedge clk);
                check("pulse_width", int'({entry_pulse, exit_pulse, timeout_pulse}), 0);
                check("count_after", int'(count), mr.cnt);
                check("err_after", int'(err), int'(mr.err));
                check("full_after", int'(full), (mr.cnt == CAP) ? 1 : 0);
                check("empty_after", int'(empty), (mr.cnt == 0) ? 1 : 0);
                mon_busy = 1'b0;
            end
        end
    end

    task automatic step(input logic [1:0] av, input logic [1:0] bv);
        a = av;
        b = bv;
        @(posedge clk);
        #1;
    endtask

    task automatic push_expect(input logic [1:0] ent, input logic [1:0] ext, input logic [1:0] tmo);
        exp_t r;
        int   n;
        n = model_count + $countones(ent) - $countones(ext);
        r.err = model_err;
        if (n > CAP) begin
            n = CAP;
            r.err = 1'b1;
        end else if (n < 0) begin
            n = 0;
            r.err = 1'b1;
        end
        r.ent  = ent;
        r.ext  = ext;
        r.tmo  = tmo;
        r.prev = model_count;
        r.cnt  = n;
        model_count = n;
        model_err   = r.err;
        q.push_back(r);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20; i++) begin
            if ((q.size() == 0) && !mon_busy) break;
            @(posedge clk);
            #2;
        end
        if ((q.size() != 0) || mon_busy) begin
            check("drain_timeout", q.size(), 0);
            q.delete();
        end
    endtask

    // Lanes in ent walk 10,11,01,00; lanes in ext walk 01,11,10,00.
    task automatic seq(input logic [1:0] ent, input logic [1:0] ext);
        step(ent, ext);
        step(ent | ext, ent | ext);
        step(ext, ent);
        push_expect(ent, ext, 2'b00);
        step(2'b00, 2'b00);
        wait_drain();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_count = 0;
        model_err   = 1'b0;
    endtask

    initial begin
        clear_err = 1'b0;
        do_reset();
        check("reset_count", int'(count), 0);
        check("reset_full", int'(full), 0);
        check("reset_empty", int'(empty), 1);
        check("reset_err", int'(err), 0);
        check("reset_pulses", int'({entry_pulse, exit_pulse, timeout_pulse}), 0);

        // Single entry on lane 0; pulse must not appear before 00 is sampled.
        step(2'b01, 2'b00);
        step(2'b01, 2'b01);
        step(2'b00, 2'b01);
        push_expect(2'b01, 2'b00, 2'b00);
        a = 2'b00;
        b = 2'b00;
        @(negedge clk);
        check("no_early_pulse", int'(entry_pulse), 0);
        @(posedge clk);
        #1;
        wait_drain();
        check("first_entry_count", int'(count), 1);

        seq(2'b11, 2'b00);
        seq(2'b11, 2'b00);
        check("count_five", int'(count), 5);
        seq(2'b00, 2'b10);
        check("exit_lane1_count", int'(count), 4);

        // Aborted, backed-out and partial sequences produce nothing.
        step(2'b01, 2'b00); step(2'b00, 2'b00);
        step(2'b00, 2'b10); step(2'b00, 2'b00);
        step(2'b01, 2'b00); step(2'b01, 2'b01); step(2'b01, 2'b00); step(2'b00, 2'b00);
        step(2'b00, 2'b10); step(2'b10, 2'b10); step(2'b00, 2'b10); step(2'b00, 2'b00);
        repeat (3) step(2'b00, 2'b00);
        wait_drain();
        check("partial_count", int'(count), 4);

        for (int i = 0; i < 47; i++) seq(2'b11, 2'b00);
        seq(2'b01, 2'b00);
        check("count_99", int'(count), 99);
        seq(2'b11, 2'b00);
        check("overflow_count", int'(count), 100);
        check("overflow_full", int'(full), 1);
        check("overflow_err", int'(err), 1);
        clear_err = 1'b1;
        @(posedge clk);
        #1;
        clear_err = 1'b0;
        model_err = 1'b0;
        check("clear_err", int'(err), 0);

        // Overflow while clear_err is held: error wins that edge, clears after.
        clear_err = 1'b1;
        seq(2'b01, 2'b00);
        check("clear_after_conflict", int'(err), 0);
        clear_err = 1'b0;
        model_err = 1'b0;

        do_reset();
        seq(2'b00, 2'b10);
        check("underflow_count", int'(count), 0);
        check("underflow_empty", int'(empty), 1);
        check("underflow_err", int'(err), 1);
        clear_err = 1'b1;
        @(posedge clk);
        #1;
        clear_err = 1'b0;
        model_err = 1'b0;

        for (int i = 0; i < 3; i++) seq(2'b11, 2'b00);
        seq(2'b01, 2'b00);
        check("count_seven", int'(count), 7);
        seq(2'b01, 2'b10);
        check("balanced_count", int'(count), 7);
        check("balanced_err", int'(err), 0);

        // Reset while lane 0 sits in AB_IN.
        do_reset();
        step(2'b01, 2'b00);
        step(2'b01, 2'b01);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (4) step(2'b00, 2'b00);
        wait_drain();
        check("reset_mid_count", int'(count), 0);
        seq(2'b01, 2'b00);
        check("restart_count", int'(count), 1);

        // Lane 0 stalled on 10.
        step(2'b01, 2'b00);
`ifdef PARKING_GATE_TIMEOUT_EN
        push_expect(2'b00, 2'b00, 2'b01);
        repeat (TMO - 1) step(2'b01, 2'b00);
        check("timeout_not_early", int'(timeout_pulse), 0);
        step(2'b01, 2'b00);
        check("timeout_fires", int'(timeout_pulse), 1);
`endif
        repeat (12) step(2'b01, 2'b00);
        step(2'b00, 2'b00);
        wait_drain();
        check("stall_count", int'(count), 1);
        seq(2'b01, 2'b00);
        check("after_stall_count", int'(count), 2);

        check("scoreboard_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: actual=1 required=0");
        $fatal(1, "simulation time limit");
    end

endmodule
`default_nettype wire
